// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline hazard controller.
//   - state encodings for the memory-wait FSM (IDLE / WAIT / ERR)
//   - hz_state_e enum built on those encodings
//   - hz_sel_e: which hazard condition currently owns the stall/flush outputs
//   - MEM_TIMEOUT_DEFAULT: default data-memory wait limit
//   - reg_match(): single source-vs-destination RAW comparison
package pipeline_pkg;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        ERR  = ST_ERR
    } hz_state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAW,
        SEL_BRANCH,
        SEL_MEM
    } hz_sel_e;

    // x0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] rd,
        input logic       wren
    );
        return used && wren && (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline and the hazard controller.
//   Pipeline -> controller: D-stage sources, E/M/W destinations, branch
//   resolution, M-stage memory request and data-memory ack.
//   Controller -> pipeline: PC/stage stalls, stage flushes, sticky memory
//   error flag and the two performance counters.
//   master: pipeline side, slave: hazard controller side.
interface hazard_ctrl_if;

    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic        rs1_used_d;
    logic        rs2_used_d;
    logic [4:0]  rd_e;
    logic [4:0]  rd_m;
    logic [4:0]  rd_w;
    logic        rd_wren_e;
    logic        rd_wren_m;
    logic        rd_wren_w;
    logic        pc_sel_e;
    logic        mem_req_m;
    logic        mem_ack;

    logic        StallPC;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushF;
    logic        FlushD;
    logic        FlushE;
    logic        FlushM;
    logic        mem_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output rs1_d, rs2_d, rs1_used_d, rs2_used_d,
        output rd_e, rd_m, rd_w, rd_wren_e, rd_wren_m, rd_wren_w,
        output pc_sel_e, mem_req_m, mem_ack,
        input  StallPC, StallF, StallD, StallE,
        input  FlushF, FlushD, FlushE, FlushM,
        input  mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_used_d, rs2_used_d,
        input  rd_e, rd_m, rd_w, rd_wren_e, rd_wren_m, rd_wren_w,
        input  pc_sel_e, mem_req_m, mem_ack,
        output StallPC, StallF, StallD, StallE,
        output FlushF, FlushD, FlushE, FlushM,
        output mem_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/raw_detect.sv
// raw_detect: combinational read-after-write detector for the D stage.
//   Inputs : rs1_d/rs2_d with their used flags, rd_e/rd_m/rd_w with their
//            write enables.
//   Output : raw_hit, set when any used nonzero source matches a writing
//            destination in E, M or W. No forwarding and no write-through
//            register file, so a W-stage match still has to stall.
module raw_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       rs1_used_d,
    input  logic       rs2_used_d,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       rd_wren_e,
    input  logic       rd_wren_m,
    input  logic       rd_wren_w,
    output logic       raw_hit
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = reg_match(rs1_d, rs1_used_d, rd_e, rd_wren_e)
               || reg_match(rs1_d, rs1_used_d, rd_m, rd_wren_m)
               || reg_match(rs1_d, rs1_used_d, rd_w, rd_wren_w);
        rs2_hit = reg_match(rs2_d, rs2_used_d, rd_e, rd_wren_e)
               || reg_match(rs2_d, rs2_used_d, rd_m, rd_wren_m)
               || reg_match(rs2_d, rs2_used_d, rd_w, rd_wren_w);
        raw_hit = rs1_hit || rs2_hit;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller.
//   Ports: i_clk (rising-edge clock), i_rst (synchronous active-high reset),
//          hz (hazard_ctrl_if.slave: pipeline status in, stalls/flushes,
//          mem_err and performance counters out).
//   Parameter MEM_TIMEOUT (1..255): consecutive data-memory wait cycles
//   tolerated before the controller locks into ERR.
//   Stall/flush outputs are combinational; only the wait FSM and the
//   counters are registered.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    hazard_ctrl_if.slave hz
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    hz_state_e   state_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;
    logic        raw_hit;
    logic        mem_wait;
    hz_sel_e     sel;

    raw_detect u_raw_detect (
        .rs1_d      (hz.rs1_d),
        .rs2_d      (hz.rs2_d),
        .rs1_used_d (hz.rs1_used_d),
        .rs2_used_d (hz.rs2_used_d),
        .rd_e       (hz.rd_e),
        .rd_m       (hz.rd_m),
        .rd_w       (hz.rd_w),
        .rd_wren_e  (hz.rd_wren_e),
        .rd_wren_m  (hz.rd_wren_m),
        .rd_wren_w  (hz.rd_wren_w),
        .raw_hit    (raw_hit)
    );

    // An ack in the same cycle as the request completes the access, so it
    // never counts as a wait.
    assign mem_wait = (state_q != ERR) && hz.mem_req_m && !hz.mem_ack;

    // Priority: ERR > mem_wait > taken branch > RAW.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == ERR || mem_wait) begin
            sel = SEL_MEM;
        end else if (hz.pc_sel_e) begin
            sel = SEL_BRANCH;
        end else if (raw_hit) begin
            sel = SEL_RAW;
        end
    end

    always_comb begin
        hz.StallPC = 1'b0;
        hz.StallF  = 1'b0;
        hz.StallD  = 1'b0;
        hz.StallE  = 1'b0;
        hz.FlushF  = 1'b0;
        hz.FlushD  = 1'b0;
        hz.FlushE  = 1'b0;
        hz.FlushM  = 1'b0;
        if (i_rst) begin
            hz.FlushF = 1'b1;
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushM = 1'b1;
        end else begin
            case (sel)
                SEL_MEM: begin
                    // Freeze everything up to EX_MEM; MEM_WB takes a bubble.
                    hz.StallPC = 1'b1;
                    hz.StallF  = 1'b1;
                    hz.StallD  = 1'b1;
                    hz.StallE  = 1'b1;
                    hz.FlushM  = 1'b1;
                end
                SEL_BRANCH: begin
                    hz.FlushF = 1'b1;
                    hz.FlushD = 1'b1;
                end
                SEL_RAW: begin
                    // Hold the D instruction, inject a bubble into E.
                    hz.StallPC = 1'b1;
                    hz.StallF  = 1'b1;
                    hz.FlushD  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_wait) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                WAIT: begin
                    // Ack wins even when the count has reached the limit.
                    if (hz.mem_ack) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == TIMEOUT) begin
                        state_q <= ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= IDLE;
            endcase

            // StallPC is asserted exactly for the MEM and RAW selections.
            if (sel == SEL_MEM || sel == SEL_RAW) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (sel == SEL_BRANCH) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign hz.mem_err      = (state_q == ERR);
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MEM_TIMEOUT = 4).
//   Each cycle the stimulus process drives inputs just after the rising
//   edge and pushes the expected stalls, flushes, mem_err and counter values;
//   the monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .hz    (hz)
    );

    typedef struct {
        string       tag;
        logic [3:0]  stall;   // {StallPC, StallF, StallD, StallE}
        logic [3:0]  flush;   // {FlushF, FlushD, FlushE, FlushM}
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.rs1_d      = '0;
        hz.rs2_d      = '0;
        hz.rs1_used_d = 1'b0;
        hz.rs2_used_d = 1'b0;
        hz.rd_e       = '0;
        hz.rd_m       = '0;
        hz.rd_w       = '0;
        hz.rd_wren_e  = 1'b0;
        hz.rd_wren_m  = 1'b0;
        hz.rd_wren_w  = 1'b0;
        hz.pc_sel_e   = 1'b0;
        hz.mem_req_m  = 1'b0;
        hz.mem_ack    = 1'b0;
    endtask

    // Push this cycle's expectation, advance the bench's counter model,
    // then move to just after the next rising edge.
    task automatic expect_cyc(input string tag, input logic [3:0] stall,
                              input logic [3:0] flush, input logic err);
        exp_t e;
        e.tag   = tag;
        e.stall = stall;
        e.flush = flush;
        e.err   = err;
        e.sc    = m_sc;
        e.fc    = m_fc;
        sb_q.push_back(e);
        if (i_rst) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (stall[3]) m_sc = m_sc + 32'd1;
            if (flush == 4'b1100 && stall == 4'b0000) m_fc = m_fc + 32'd1;
        end
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq({e.tag, ".stall"},
                     32'({hz.StallPC, hz.StallF, hz.StallD, hz.StallE}), 32'(e.stall));
            check_eq({e.tag, ".flush"},
                     32'({hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM}), 32'(e.flush));
            check_eq({e.tag, ".mem_err"}, 32'(hz.mem_err), 32'(e.err));
            check_eq({e.tag, ".stall_cycles"}, hz.stall_cycles, e.sc);
            check_eq({e.tag, ".flush_count"}, hz.flush_count, e.fc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        expect_cyc("rst", 4'b0000, 4'b1111, 1'b0);
        i_rst = 1'b0;
        expect_cyc("idle", 4'b0000, 4'b0000, 1'b0);

        // Load-use dependency walking down E, M, W.
        hz.rs1_d = 5'd5; hz.rs1_used_d = 1'b1;
        hz.rd_e = 5'd5;  hz.rd_wren_e = 1'b1;
        expect_cyc("raw_e", 4'b1100, 4'b0100, 1'b0);
        hz.rd_e = '0;    hz.rd_wren_e = 1'b0;
        hz.rd_m = 5'd5;  hz.rd_wren_m = 1'b1;
        expect_cyc("raw_m", 4'b1100, 4'b0100, 1'b0);
        hz.rd_m = '0;    hz.rd_wren_m = 1'b0;
        hz.rd_w = 5'd5;  hz.rd_wren_w = 1'b1;
        expect_cyc("raw_w", 4'b1100, 4'b0100, 1'b0);
        clear_inputs();
        expect_cyc("raw_done", 4'b0000, 4'b0000, 1'b0);

        // rs2 path: used flag and write enable both gate the match.
        hz.rs2_d = 5'd7; hz.rd_m = 5'd7; hz.rd_wren_m = 1'b1;
        expect_cyc("rs2_unused", 4'b0000, 4'b0000, 1'b0);
        hz.rs2_used_d = 1'b1;
        expect_cyc("rs2_raw", 4'b1100, 4'b0100, 1'b0);
        hz.rd_wren_m = 1'b0;
        expect_cyc("rs2_nowren", 4'b0000, 4'b0000, 1'b0);

        // x0 never creates a dependency.
        clear_inputs();
        hz.rs1_used_d = 1'b1; hz.rd_wren_e = 1'b1;
        expect_cyc("x0", 4'b0000, 4'b0000, 1'b0);

        // Taken branch outranks RAW.
        hz.rs1_d = 5'd3; hz.rd_e = 5'd3; hz.pc_sel_e = 1'b1;
        expect_cyc("br_raw", 4'b0000, 4'b1100, 1'b0);
        clear_inputs();
        hz.pc_sel_e = 1'b1;
        expect_cyc("br_only", 4'b0000, 4'b1100, 1'b0);
        clear_inputs();
        expect_cyc("br_done", 4'b0000, 4'b0000, 1'b0);

        // Memory wait of three cycles; first cycle also has branch + RAW.
        hz.mem_req_m = 1'b1;
        hz.rs1_d = 5'd9; hz.rs1_used_d = 1'b1; hz.rd_e = 5'd9; hz.rd_wren_e = 1'b1;
        hz.pc_sel_e = 1'b1;
        expect_cyc("mw1", 4'b1111, 4'b0001, 1'b0);
        clear_inputs();
        hz.mem_req_m = 1'b1;
        expect_cyc("mw2", 4'b1111, 4'b0001, 1'b0);
        expect_cyc("mw3", 4'b1111, 4'b0001, 1'b0);
        hz.mem_ack = 1'b1;
        expect_cyc("mw_ack", 4'b0000, 4'b0000, 1'b0);
        clear_inputs();
        expect_cyc("mw_done", 4'b0000, 4'b0000, 1'b0);

        // Same-cycle ack from IDLE, then an ack exactly at the limit.
        hz.mem_req_m = 1'b1; hz.mem_ack = 1'b1;
        expect_cyc("req_ack", 4'b0000, 4'b0000, 1'b0);
        hz.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_cyc("lim_wait", 4'b1111, 4'b0001, 1'b0);
        end
        hz.mem_ack = 1'b1;
        expect_cyc("lim_ack", 4'b0000, 4'b0000, 1'b0);
        clear_inputs();
        expect_cyc("lim_done", 4'b0000, 4'b0000, 1'b0);

        // Timeout: five stalled wait cycles, then ERR overrides everything.
        hz.mem_req_m = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_cyc("to_wait", 4'b1111, 4'b0001, 1'b0);
        end
        clear_inputs();
        hz.pc_sel_e = 1'b1;
        expect_cyc("err1", 4'b1111, 4'b0001, 1'b1);
        hz.pc_sel_e = 1'b0; hz.mem_ack = 1'b1;
        expect_cyc("err2", 4'b1111, 4'b0001, 1'b1);
        clear_inputs();

        // Reset out of ERR.
        i_rst = 1'b1;
        expect_cyc("rst_err", 4'b0000, 4'b1111, 1'b1);
        i_rst = 1'b0;
        expect_cyc("post_rst", 4'b0000, 4'b0000, 1'b0);

        // stall_cycles wrap.
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        m_sc = 32'hFFFF_FFFF;
        hz.rs1_d = 5'd12; hz.rs1_used_d = 1'b1; hz.rd_w = 5'd12; hz.rd_wren_w = 1'b1;
        expect_cyc("wrap_pre", 4'b1100, 4'b0100, 1'b0);
        clear_inputs();
        expect_cyc("wrap_post", 4'b0000, 4'b0000, 1'b0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
